// File: rtl/comparator_pkg.sv
// Shared types and constants for the digit-serial magnitude comparator.
package comparator_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } res_t;

  localparam res_t RES_GT = 3'b100;
  localparam res_t RES_EQ = 3'b010;
  localparam res_t RES_LT = 3'b001;

endpackage

// File: rtl/comparator_digit.sv
// Combinational unsigned compare of one DIGIT-bit slice of each operand.
module comparator_digit
  import comparator_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output res_t             res
);

  always_comb begin
    res = RES_EQ;
    if (a > b)      res = RES_GT;
    else if (a < b) res = RES_LT;
  end

endmodule

// File: rtl/comparator_serial.sv
// Digit-serial cascadable magnitude comparator: MS digit first, stops at the
// first unequal digit, falls back to the latched cascade inputs on full equality.
module comparator_serial
  import comparator_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int DIGIT     = 4,
  parameter int SIGNED_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             i_a_gt_b,
  input  logic             i_a_eq_b,
  input  logic             i_a_lt_b,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_a_gt_b,
  output logic             o_a_eq_b,
  output logic             o_a_lt_b
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(NDIG - 1);

  state_t           state, state_d;
  logic [IDX_W-1:0] idx, idx_d;
  logic             busy_d, done_d, load;
  res_t             res_q, res_d;

  logic [WIDTH-1:0] a_q, b_q;
  res_t             casc_q;
  logic             signed_q;

  logic [DIGIT-1:0] dig_a, dig_b;
  res_t             dig_res;

  // Inverting the sign bit of the top digit maps two's complement onto unsigned order.
  always_comb begin
    dig_a = a_q[idx*DIGIT +: DIGIT];
    dig_b = b_q[idx*DIGIT +: DIGIT];
    if (signed_q && (idx == TOP_IDX)) begin
      dig_a[DIGIT-1] = ~dig_a[DIGIT-1];
      dig_b[DIGIT-1] = ~dig_b[DIGIT-1];
    end
  end

  comparator_digit #(.DIGIT(DIGIT)) u_digit (
    .a   (dig_a),
    .b   (dig_b),
    .res (dig_res)
  );

  always_comb begin
    state_d = state;
    idx_d   = idx;
    busy_d  = o_busy;
    done_d  = 1'b0;
    res_d   = res_q;
    load    = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          load    = 1'b1;
          idx_d   = TOP_IDX;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (dig_res != RES_EQ) begin
          res_d   = dig_res;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (idx != '0) begin
          idx_d = idx - 1'b1;
        end else begin
          res_d   = casc_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      res_q  <= RES_EQ;
    end else begin
      state  <= state_d;
      idx    <= idx_d;
      o_busy <= busy_d;
      o_done <= done_d;
      res_q  <= res_d;
    end
  end

  // Operand capture is pure data and needs no reset.
  always_ff @(posedge clk) begin
    if (load) begin
      a_q      <= a;
      b_q      <= b;
      casc_q   <= res_t'({i_a_gt_b, i_a_eq_b, i_a_lt_b});
      signed_q <= (SIGNED_EN != 0) && i_signed;
    end
  end

  assign o_a_gt_b = res_q.gt;
  assign o_a_eq_b = res_q.eq;
  assign o_a_lt_b = res_q.lt;

endmodule
